alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered signed two's-complement ALU, 32-bit by default.
- Performs one of eight arithmetic/logic operations per cycle, selected by Opcode.
- Reports Overflow, Underflow and Error (divide-by-zero) flags alongside Result.
- Sits behind the alu_interface bus: the driver updates inputs on the falling edge; the monitor samples on the rising edge.

Parameters:
- WIDTH, 32, operand/result width in bits. The bench uses only 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  signed operand 1.
- B  input  WIDTH  signed operand 2.
- Opcode  input  3  operation select.
- Result  output  WIDTH  signed registered result.
- Overflow  output  1  registered; true result exceeded the maximum positive value.
- Underflow  output  1  registered; true result fell below the minimum negative value.
- Error  output  1  registered; illegal operation (divide or modulo by zero).

Behaviour:
- Reset: while rst=1, Result=0, Overflow=0, Underflow=0, Error=0 immediately, independent of clk. Operation resumes on the first rising edge after rst deasserts.
- Latency: 1 cycle.
  - A, B and Opcode are sampled on the rising edge.
  - Result and flags for those inputs are valid right after that edge and hold until the next edge.
  - No handshake; a new operation is accepted every cycle.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: bitwise.
  - 011 OR: bitwise.
  - 100 XOR: bitwise.
  - 101 MUL: signed product; Result = low WIDTH bits of the 2·WIDTH product.
  - 110 DIV: signed quotient, truncated toward zero.
  - 111 MOD: signed remainder; its sign follows A.
- Flag computation: on the exact mathematical result, using WIDTH+1 bits for ADD/SUB and 2·WIDTH bits for MUL.
  - Overflow=1 if the true result > 2^(WIDTH−1)−1.
  - Underflow=1 if the true result < −2^(WIDTH−1).
  - At most one of Overflow, Underflow, Error is set in any cycle.
- Logic ops (AND/OR/XOR): all flags 0.
- DIV/MOD with B=0: Error=1, Result=0, Overflow=0, Underflow=0.
- DIV of MIN by −1: Overflow=1, Result=MIN (wraps), Error=0.
- MOD of MIN by −1: Result=0, no flags.
- Flags are not sticky; they are recomputed every cycle.
- Reset asserted mid-stream clears all outputs at once. The first post-reset edge computes from the current inputs.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined: on Overflow, Result=MAX (0x7FFFFFFF); on Underflow, Result=MIN (0x80000000). This applies to ADD, SUB, MUL and DIV MIN/−1. Flags are still reported.
- Undefined: Result wraps modulo 2^WIDTH. Flags are unchanged.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] opcode_t: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_MOD.
  - localparams ALU_MAX and ALU_MIN, derived from WIDTH=32.
- One sub-module, alu_datapath: purely combinational; computes the next Result and the three flags from A, B and Opcode.
- alu_core instantiates alu_datapath and holds only the output register with its asynchronous reset.

Test Plan:
- Reset: assert rst with non-zero inputs → Result=0 and all flags 0 immediately, with no clock edge needed.
- ADD overflow: A=0x7FFFFFFF, B=1, Op=000 → next edge Overflow=1. Result=0x80000000, or 0x7FFFFFFF with ALU_SATURATE_EN.
- SUB underflow: A=0x80000000, B=1, Op=001 → Underflow=1. Result=0x7FFFFFFF, or 0x80000000 with ALU_SATURATE_EN.
- Logic: A=0xF0F0F0F0, B=0x0FF00FF0 → AND=0x00F000F0, OR=0xFFF0FFF0, XOR=0xFF00FF00; all flags 0.
- MUL/DIV/MOD:
  - A=−7, B=3 → MUL=−21, DIV=−2, MOD=−1.
  - A=0x10000, B=0x10000, MUL → Overflow=1, Result=0 (wrap).
- Divide by zero: A=5, B=0, Op=110 and Op=111 → Error=1, Result=0. Next cycle, with a legal op, Error returns to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the registered ALU.
// Optional macro ALU_SATURATE_EN selects saturating results (see alu_datapath).
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic signed [ALU_WIDTH-1:0] ALU_MAX = {1'b0, {(ALU_WIDTH-1){1'b1}}};
  localparam logic signed [ALU_WIDTH-1:0] ALU_MIN = {1'b1, {(ALU_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_MOD = 3'b111
  } opcode_t;

endpackage

// File: rtl/alu_if.sv
// ALU bus: operands and opcode in, registered result and flags out.
// The driver changes inputs on the falling edge; the monitor samples on the rising edge.
interface alu_if #(
  parameter int WIDTH = 32
) ();

  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic        [2:0]       Opcode;
  logic signed [WIDTH-1:0] Result;
  logic                    Overflow;
  logic                    Underflow;
  logic                    Error;

  modport master (
    output A, B, Opcode,
    input  Result, Overflow, Underflow, Error
  );

  modport slave (
    input  A, B, Opcode,
    output Result, Overflow, Underflow, Error
  );

endinterface

// File: rtl/alu_datapath.sv
// Combinational ALU: next result and flags from A, B and opcode.
// With ALU_SATURATE_EN defined, overflowing results clamp to MAX/MIN instead of wrapping.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [2:0]       opcode,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    error
);

  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_ONE = {WIDTH{1'b1}};
  localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  opcode_t op;
  logic signed [WIDTH:0]       sum_ext;
  logic signed [WIDTH:0]       diff_ext;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [WIDTH-1:0]     divisor;
  logic signed [WIDTH-1:0]     quot;
  logic signed [WIDTH-1:0]     rem;
  logic signed [WIDTH-1:0]     raw_result;
  logic                        div_zero;
  logic                        min_by_neg1;
  logic                        prod_fits;

  assign op = opcode_t'(opcode);

  // One extra bit for add/sub and full double width for multiply keep the true result exact.
  assign sum_ext  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign diff_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign prod     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_fits = (&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]);

  // Divide by one instead of zero or MIN/-1: quotient then equals the wrapped MIN and remainder 0.
  assign div_zero    = (b == '0);
  assign min_by_neg1 = (a == MIN_VAL) && (b == NEG_ONE);
  assign divisor     = (div_zero || min_by_neg1) ? ONE : b;
  assign quot        = a / divisor;
  assign rem         = a % divisor;

  always_comb begin
    raw_result = '0;
    overflow   = 1'b0;
    underflow  = 1'b0;
    error      = 1'b0;
    case (op)
      OP_ADD: begin
        raw_result = sum_ext[WIDTH-1:0];
        overflow   = ~sum_ext[WIDTH] & sum_ext[WIDTH-1];
        underflow  = sum_ext[WIDTH] & ~sum_ext[WIDTH-1];
      end
      OP_SUB: begin
        raw_result = diff_ext[WIDTH-1:0];
        overflow   = ~diff_ext[WIDTH] & diff_ext[WIDTH-1];
        underflow  = diff_ext[WIDTH] & ~diff_ext[WIDTH-1];
      end
      OP_AND: raw_result = a & b;
      OP_OR:  raw_result = a | b;
      OP_XOR: raw_result = a ^ b;
      OP_MUL: begin
        raw_result = prod[WIDTH-1:0];
        overflow   = ~prod_fits & ~prod[2*WIDTH-1];
        underflow  = ~prod_fits & prod[2*WIDTH-1];
      end
      OP_DIV: begin
        if (div_zero) begin
          error = 1'b1;
        end else begin
          raw_result = quot;
          overflow   = min_by_neg1;
        end
      end
      OP_MOD: begin
        if (div_zero) begin
          error = 1'b1;
        end else begin
          raw_result = rem;
        end
      end
    endcase
  end

`ifdef ALU_SATURATE_EN
  assign result = overflow ? MAX_VAL : (underflow ? MIN_VAL : raw_result);
`else
  assign result = raw_result;
`endif

endmodule

// File: rtl/alu_core.sv
// Registered signed ALU: one-cycle latency, asynchronous active-high reset.
// ALU_SATURATE_EN (in alu_datapath) switches wrapped results to saturated ones.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  logic signed [WIDTH-1:0] result_next;
  logic                    overflow_next;
  logic                    underflow_next;
  logic                    error_next;

  logic signed [WIDTH-1:0] result_reg;
  logic                    overflow_reg;
  logic                    underflow_reg;
  logic                    error_reg;

  alu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .a         (bus.A),
    .b         (bus.B),
    .opcode    (bus.Opcode),
    .result    (result_next),
    .overflow  (overflow_next),
    .underflow (underflow_next),
    .error     (error_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      result_reg    <= result_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      error_reg     <= error_next;
    end
  end

  assign bus.Result    = result_reg;
  assign bus.Overflow  = overflow_reg;
  assign bus.Underflow = underflow_reg;
  assign bus.Error     = error_reg;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: a 64-bit reference model fills a scoreboard queue
// at drive time; results are popped and checked 1 ns after the next rising edge.
module tb_alu_core;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        er;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input string tag);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint t;
    logic   range_op;
    logic [63:0] tv;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.res = '0; e.ov = 1'b0; e.un = 1'b0; e.er = 1'b0; e.tag = tag;
    range_op = 1'b1;
    t = 0;
    case (op)
      3'd0: t = sa + sb_v;
      3'd1: t = sa - sb_v;
      3'd2: begin e.res = a & b; range_op = 1'b0; end
      3'd3: begin e.res = a | b; range_op = 1'b0; end
      3'd4: begin e.res = a ^ b; range_op = 1'b0; end
      3'd5: t = sa * sb_v;
      3'd6: if (sb_v == 0) begin e.er = 1'b1; range_op = 1'b0; end else t = sa / sb_v;
      default: if (sb_v == 0) begin e.er = 1'b1; range_op = 1'b0; end else t = sa % sb_v;
    endcase
    if (range_op) begin
      tv = t;
      e.res = tv[31:0];
      if (t > 64'sd2147483647) e.ov = 1'b1;
      if (t < -64'sd2147483648) e.un = 1'b1;
`ifdef ALU_SATURATE_EN
      if (e.ov) e.res = 32'h7FFF_FFFF;
      if (e.un) e.res = 32'h8000_0000;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk({e.tag, ".result"}, bus.Result, e.res);
    chk({e.tag, ".ovf"}, {31'd0, bus.Overflow}, {31'd0, e.ov});
    chk({e.tag, ".unf"}, {31'd0, bus.Underflow}, {31'd0, e.un});
    chk({e.tag, ".err"}, {31'd0, bus.Error}, {31'd0, e.er});
    $display("op %-10s result=%h ovf=%b unf=%b err=%b", e.tag, bus.Result,
             bus.Overflow, bus.Underflow, bus.Error);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk_outputs(e);
  endtask

  // Drive on the falling edge, check 1 ns after the following rising edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input string tag);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Opcode = op;
    sb.push_back(model(a, b, op, tag));
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic chk_reset(input string tag);
    exp_t z;
    z.res = '0; z.ov = 1'b0; z.un = 1'b0; z.er = 1'b0; z.tag = tag;
    chk_outputs(z);
  endtask

  initial begin
    // Non-zero inputs while reset is held from time zero.
    bus.A = 32'h7FFF_FFFF; bus.B = 32'd1; bus.Opcode = 3'd0;
    #3;
    chk_reset("reset0");
    @(negedge clk);
    rst = 1'b0;

    do_op(32'h7FFF_FFFF, 32'd1,          3'd0, "add_ovf");
`ifdef ALU_SATURATE_EN
    chk("add_ovf_const", bus.Result, ALU_MAX);
`else
    chk("add_ovf_const", bus.Result, ALU_MIN);
`endif
    do_op(32'h8000_0000, 32'd1,          3'd1, "sub_unf");
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0,  3'd2, "and");
    chk("and_const", bus.Result, 32'h00F0_00F0);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0,  3'd3, "or");
    chk("or_const", bus.Result, 32'hFFF0_FFF0);
    do_op(32'hF0F0_F0F0, 32'h0FF0_0FF0,  3'd4, "xor");
    chk("xor_const", bus.Result, 32'hFF00_FF00);
    do_op(-32'sd7,       32'sd3,         3'd5, "mul_m7_3");
    chk("mul_const", bus.Result, -32'sd21);
    do_op(-32'sd7,       32'sd3,         3'd6, "div_m7_3");
    chk("div_const", bus.Result, -32'sd2);
    do_op(-32'sd7,       32'sd3,         3'd7, "mod_m7_3");
    chk("mod_const", bus.Result, -32'sd1);
    do_op(32'h0001_0000, 32'h0001_0000,  3'd5, "mul_ovf");
    do_op(32'h0001_0000, 32'hFFFF_0000,  3'd5, "mul_unf");
    do_op(32'd5,         32'd0,          3'd6, "div_zero");
    do_op(32'd5,         32'd0,          3'd7, "mod_zero");
    do_op(32'd5,         32'd0,          3'd0, "after_err");
    do_op(32'h8000_0000, 32'hFFFF_FFFF,  3'd6, "div_min_m1");
    do_op(32'h8000_0000, 32'hFFFF_FFFF,  3'd7, "mod_min_m1");
    do_op(32'h8000_0000, 32'hFFFF_FFFF,  3'd0, "add_unf");
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF,  3'd1, "sub_ovf");
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF,  3'd5, "mul_max");
    do_op(32'h8000_0000, 32'd2,          3'd5, "mul_min2");
    do_op(32'h8000_0000, 32'h8000_0000,  3'd5, "mul_minsq");
    do_op(32'd17,        -32'sd5,        3'd7, "mod_17_m5");
    do_op(32'd17,        -32'sd5,        3'd6, "div_17_m5");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom();
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      do_op(ra, rb, 3'(i % 8), $sformatf("rand%0d", i));
    end

    // Mid-stream reset: outputs clear before any clock edge.
    do_op(32'h7FFF_FFFF, 32'd1, 3'd0, "pre_rst");
    @(negedge clk);
    bus.A = 32'd100; bus.B = 32'd23; bus.Opcode = 3'd1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("reset_mid");
    @(negedge clk);
    chk_reset("reset_hold");
    rst = 1'b0;
    sb.push_back(model(32'd100, 32'd23, 3'd1, "post_rst"));
    @(posedge clk);
    #1;
    pop_check();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
